// File: rtl/mem_responder.sv
// Word-wide load/store bus target with an internal word store.
// Fixed wait states before a one-cycle ack; err flags out-of-range accesses.
module mem_responder #(
  parameter int                ADDR_W      = 30,
  parameter int                DEPTH_LOG2  = 10,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_WORD   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data,
  output logic [31:0]       q,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic capture, access;

  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic              acc_wren;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_data;
  logic [ADDR_W-1:0] off;
  logic              in_range;
  logic [DEPTH_LOG2-1:0] idx;

  logic [31:0] mem [2**DEPTH_LOG2];

  // Next-state logic: capture in IDLE, count wait states, single RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With no wait states the access happens on the capture edge itself,
  // so the live inputs are used while IDLE.
  always_comb begin
    acc_wren = wren_q;
    acc_addr = addr_q;
    acc_data = data_q;
    if (state_q == S_IDLE) begin
      acc_wren = wren;
      acc_addr = address;
      acc_data = data;
    end
    off      = acc_addr - BASE_WORD;
    in_range = (acc_addr >= BASE_WORD) &&
               ((off >> DEPTH_LOG2) == '0);
    idx      = off[DEPTH_LOG2-1:0];
  end

  // State, capture registers, response outputs and the word store.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      q       <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wren_q <= wren;
        addr_q <= address;
        data_q <= data;
      end
      ack  <= access;
      err  <= access && !in_range;
      busy <= (state_d != S_IDLE);
      if (access && !acc_wren) begin
        q <= in_range ? mem[idx] : 32'h0;
      end
      if (access && acc_wren && in_range) begin
        mem[idx] <= acc_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two builds driven by shared stimulus,
// checked every cycle against a transaction-level model.
module tb_mem_responder;

  localparam int AW = 30;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          req     = 1'b0;
  logic          wren    = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   data    = '0;

  logic [31:0] q    [2];
  logic        ack  [2];
  logic        err  [2];
  logic        busy [2];

  int checks   = 0;
  int failures = 0;

  mem_responder #(
    .ADDR_W(30), .DEPTH_LOG2(10),
    .WAIT_CYCLES(2), .BASE_WORD(30'h0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .wren(wren), .address(address), .data(data),
    .q(q[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );

  mem_responder #(
    .ADDR_W(30), .DEPTH_LOG2(4),
    .WAIT_CYCLES(0), .BASE_WORD(30'h100)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req),
    .wren(wren), .address(address), .data(data),
    .q(q[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  longint p_wait [2] = '{2, 0};
  longint p_base [2] = '{0, 'h100};
  longint p_size [2] = '{1024, 16};

  longint        e = 0;
  bit            act    [2];
  longint        acc_e  [2];
  logic          c_wren [2];
  logic [AW-1:0] c_addr [2];
  logic [31:0]   c_data [2];
  logic [31:0]   exp_q  [2] = '{0, 0};
  bit            exp_ack  [2];
  bit            exp_err  [2];
  bit            exp_busy [2];
  bit            q_known  [2] = '{1, 1};
  logic [31:0]   mm [longint];

  function automatic bit in_rng(int i, logic [AW-1:0] a);
    longint av = longint'(a);
    return (av >= p_base[i]) && ((av - p_base[i]) < p_size[i]);
  endfunction

  function automatic longint key_of(int i, logic [AW-1:0] a);
    return longint'(i) * (64'd1 << 20) + (longint'(a) - p_base[i]);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: capture edge, access edge, release edge.
  initial begin
    bit ok;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < 2; i++) begin
          act[i] = 0; exp_ack[i] = 0; exp_err[i] = 0;
          exp_busy[i] = 0; exp_q[i] = '0; q_known[i] = 1;
        end
      end else begin
        e++;
        for (int i = 0; i < 2; i++) begin
          exp_ack[i] = 0;
          exp_err[i] = 0;
          if (act[i] && e == acc_e[i] + 1) begin
            act[i] = 0;
          end else if (!act[i] && req) begin
            act[i] = 1;
            c_wren[i] = wren;
            c_addr[i] = address;
            c_data[i] = data;
            acc_e[i] = e + p_wait[i];
          end
          if (act[i] && e == acc_e[i]) begin
            ok = in_rng(i, c_addr[i]);
            exp_ack[i] = 1;
            exp_err[i] = !ok;
            if (c_wren[i]) begin
              if (ok) mm[key_of(i, c_addr[i])] = c_data[i];
            end else if (!ok) begin
              exp_q[i] = '0;
              q_known[i] = 1;
            end else if (mm.exists(key_of(i, c_addr[i]))) begin
              exp_q[i] = mm[key_of(i, c_addr[i])];
              q_known[i] = 1;
            end else begin
              q_known[i] = 0;
            end
          end
          exp_busy[i] = act[i];
        end
      end
    end
  end

  // Per-cycle comparison of both builds against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cmp_ack%0d", i), 32'(ack[i]), 32'(exp_ack[i]));
        chk($sformatf("cmp_err%0d", i), 32'(err[i]), 32'(exp_err[i]));
        chk($sformatf("cmp_busy%0d", i), 32'(busy[i]), 32'(exp_busy[i]));
        if (q_known[i]) chk($sformatf("cmp_q%0d", i), q[i], exp_q[i]);
      end
    end
  end

  task automatic issue(bit w, logic [AW-1:0] a, logic [31:0] d,
                       output longint ce);
    @(negedge clk);
    req = 1'b1; wren = w; address = a; data = d;
    @(posedge clk);
    #1;
    ce = e;
    @(negedge clk);
    req = 1'b0;
    wren = 1'($urandom);
    address = AW'($urandom);
    data = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= 50), 32'd0);
  endtask

  task automatic wait_ack(int i, output longint ae,
                          output logic [31:0] qv, output logic ev);
    ae = -1; qv = '0; ev = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (ack[i]) begin
        ae = e; qv = q[i]; ev = err[i];
        break;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("ack_timeout%0d", i), 32'(ae < 0), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    longint ce, ae;
    longint ak [3];
    logic [31:0] qv;
    logic ev;
    int n;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", 32'(ack[i]), 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_q", q[i], 32'h0);
    end
    reset_n = 1'b1;

    issue(1, 30'd5, 32'hCAFE_0001, ce);
    wait_ack(0, ae, qv, ev);
    chk("t1_st_lat", 32'(ae - ce), 32'd2);
    chk("t1_st_err", 32'(ev), 32'd0);
    wait_idle();
    issue(0, 30'd5, 32'h0, ce);
    wait_ack(0, ae, qv, ev);
    chk("t1_ld_lat", 32'(ae - ce), 32'd2);
    chk("t1_ld_q", qv, 32'hCAFE_0001);
    chk("t1_ld_err", 32'(ev), 32'd0);
    wait_idle();

    issue(1, 30'h100, 32'h1234_5678, ce);
    wait_idle();
    issue(0, 30'h100, 32'h0, ce);
    chk("t2_busy", 32'(busy[1]), 32'd1);
    wait_ack(1, ae, qv, ev);
    chk("t2_lat", 32'(ae - ce), 32'd0);
    chk("t2_q", qv, 32'h1234_5678);
    @(negedge clk);
    chk("t2_busy_drop", 32'(busy[1]), 32'd0);
    wait_idle();
    issue(0, 30'h0FF, 32'h0, ce);
    wait_ack(1, ae, qv, ev);
    chk("t6_err", 32'(ev), 32'd1);
    wait_idle();

    issue(1, 30'd0, 32'hA5A5_0000, ce);
    wait_idle();
    issue(1, 30'd1024, 32'hDEAD_BEEF, ce);
    wait_ack(0, ae, qv, ev);
    chk("t3_st_err", 32'(ev), 32'd1);
    wait_idle();
    issue(0, 30'd0, 32'h0, ce);
    wait_ack(0, ae, qv, ev);
    chk("t3_word0", qv, 32'hA5A5_0000);
    wait_idle();
    issue(0, 30'd1024, 32'h0, ce);
    wait_ack(0, ae, qv, ev);
    chk("t3_ld_q", qv, 32'h0);
    chk("t3_ld_err", 32'(ev), 32'd1);
    wait_idle();

    for (int k = 1; k <= 3; k++) begin
      issue(1, AW'(k), 32'h11 * k, ce);
      wait_idle();
    end
    @(negedge clk);
    req = 1'b1; wren = 1'b0; address = 30'd1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(0, ak[k], qv, ev);
      chk("t4_q", qv, 32'h11 * (k + 1));
      @(negedge clk);
      if (k < 2) address = AW'(k + 2);
      else req = 1'b0;
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    chk("t4_gap1", 32'(ak[1] - ak[0]), 32'd4);
    chk("t4_gap2", 32'(ak[2] - ak[1]), 32'd4);
    wait_idle();

    issue(1, 30'd7, 32'h0000_0777, ce);
    wait_idle();
    issue(1, 30'd7, 32'hFFFF_FFFF, ce);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ack[0]) n++;
    end
    chk("t5_no_ack", 32'(n), 32'd0);
    issue(0, 30'd7, 32'h0, ce);
    wait_ack(0, ae, qv, ev);
    chk("t5_q", qv, 32'h0000_0777);
    wait_idle();

    repeat (400) begin
      @(negedge clk);
      req = ($urandom_range(0, 2) == 0);
      wren = 1'($urandom);
      data = $urandom;
      case ($urandom_range(0, 4))
        0: address = AW'($urandom_range(0, 15));
        1: address = AW'(32'h100 + $urandom_range(0, 15));
        2: address = AW'(32'h0F8 + $urandom_range(0, 15));
        3: address = AW'(1020 + $urandom_range(0, 8));
        default: address = AW'($urandom);
      endcase
    end
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
